// File: rtl/cpu_types_pkg.sv
// Shared CPU datapath types plus the forwarding-unit FSM state encoding.
// Default widths of the forwarding unit come from word_t and regbits_t.
package cpu_types_pkg;

    localparam int unsigned WordW = 32;
    localparam int unsigned RegW  = 5;

    typedef logic [WordW-1:0] word_t;
    typedef logic [RegW-1:0]  regbits_t;

    typedef enum logic [1:0] {
        StRun      = 2'd0,
        StLoadWait = 2'd1,
        StHeld     = 2'd2
    } fwd_state_t;

endpackage

// File: rtl/fwd_operand_sel.sv
// Combinational bypass mux for one consumer operand: youngest matching producer wins,
// and the unresolved flag marks a dependence on stage-0 load data that has not arrived.
module fwd_operand_sel
    import cpu_types_pkg::*;
#(
    parameter int unsigned NFWD  = 2,
    parameter int unsigned REGW  = $bits(regbits_t),
    parameter int unsigned DATAW = $bits(word_t)
) (
    input  logic                    used,
    input  logic [REGW-1:0]         sel,
    input  logic [DATAW-1:0]        rf,
    input  logic                    cap_valid,
    input  logic [NFWD-1:0]         prod_wen,
    input  logic [NFWD*REGW-1:0]    prod_wsel,
    input  logic [NFWD-1:0]         prod_is_load,
    input  logic [NFWD*DATAW-1:0]   prod_data,
    input  logic [DATAW-1:0]        load_data,
    input  logic                    load_ready,
    input  logic [DATAW-1:0]        wb_load_data,
    output logic [DATAW-1:0]        value,
    output logic                    unresolved
);

    logic [NFWD-1:0] match;

    always_comb begin
        match = '0;
        for (int k = 0; k < int'(NFWD); k++) begin
            match[k] = prod_wen[k]
                    && (prod_wsel[k*REGW +: REGW] != '0)
                    && (prod_wsel[k*REGW +: REGW] == sel);
        end
    end

    // Walk oldest to youngest so the youngest match overwrites everything older.
    always_comb begin
        value = rf;
        for (int k = int'(NFWD) - 1; k >= 0; k--) begin
            if (match[k]) begin
                if (prod_is_load[k] && k == 0) begin
                    value = load_data;
                end else if (prod_is_load[k] && k == int'(NFWD) - 1) begin
                    value = wb_load_data;
                end else begin
                    value = prod_data[k*DATAW +: DATAW];
                end
            end
        end
    end

    // Older stages may hold the same register, but only the youngest match is architecturally
    // correct, so an outstanding stage-0 load blocks the operand.
    always_comb begin
        unresolved = used && match[0] && prod_is_load[0] && !load_ready && !cap_valid;
    end

endmodule

// File: rtl/fwd_hazard_unit.sv
// Operand forwarding and load-use hazard unit: per-operand bypass muxes, a capture buffer
// that keeps forwarded values stable across consumer holds, a state FSM and a stall counter.
module fwd_hazard_unit
    import cpu_types_pkg::*;
#(
    parameter int unsigned NSRC  = 3,
    parameter int unsigned NFWD  = 2,
    parameter int unsigned REGW  = $bits(regbits_t),
    parameter int unsigned DATAW = $bits(word_t),
    parameter int unsigned CNTW  = 16
) (
    input  logic                    CLK,
    input  logic                    nRST,
    input  logic                    flush,
    input  logic                    consumer_hold,
    input  logic [NSRC-1:0]         src_used,
    input  logic [NSRC*REGW-1:0]    src_sel,
    input  logic [NSRC*DATAW-1:0]   src_rf,
    input  logic [NFWD-1:0]         prod_wen,
    input  logic [NFWD*REGW-1:0]    prod_wsel,
    input  logic [NFWD-1:0]         prod_is_load,
    input  logic [NFWD*DATAW-1:0]   prod_data,
    input  logic [DATAW-1:0]        load_data,
    input  logic                    load_ready,
    input  logic [DATAW-1:0]        wb_load_data,
    output logic [NSRC*DATAW-1:0]   fwd_data,
    output logic                    stall_req,
    output logic [1:0]              fwd_state,
    output logic [CNTW-1:0]         stall_count
);

    logic [DATAW-1:0] sel_value [NSRC];
    logic [NSRC-1:0]  unresolved;

    logic [NSRC-1:0]  cap_valid_q, cap_valid_d;
    logic [DATAW-1:0] cap_data_q [NSRC];
    logic [DATAW-1:0] cap_data_d [NSRC];

    fwd_state_t       state_q, state_d;
    logic [CNTW-1:0]  count_q, count_d;

    for (genvar g = 0; g < NSRC; g++) begin : g_src
        fwd_operand_sel #(
            .NFWD  (NFWD),
            .REGW  (REGW),
            .DATAW (DATAW)
        ) u_sel (
            .used         (src_used[g]),
            .sel          (src_sel[g*REGW +: REGW]),
            .rf           (src_rf[g*DATAW +: DATAW]),
            .cap_valid    (cap_valid_q[g]),
            .prod_wen     (prod_wen),
            .prod_wsel    (prod_wsel),
            .prod_is_load (prod_is_load),
            .prod_data    (prod_data),
            .load_data    (load_data),
            .load_ready   (load_ready),
            .wb_load_data (wb_load_data),
            .value        (sel_value[g]),
            .unresolved   (unresolved[g])
        );
    end

    always_comb begin
        fwd_data = '0;
        for (int i = 0; i < int'(NSRC); i++) begin
            fwd_data[i*DATAW +: DATAW] = cap_valid_q[i] ? cap_data_q[i] : sel_value[i];
        end
    end

    assign stall_req = |unresolved;

    // Unresolved operands are not captured; they keep tracking until the load lands.
    always_comb begin
        cap_valid_d = cap_valid_q;
        for (int i = 0; i < int'(NSRC); i++) begin
            cap_data_d[i] = cap_data_q[i];
            if (flush || !consumer_hold) begin
                cap_valid_d[i] = 1'b0;
            end else if (!cap_valid_q[i] && !unresolved[i]) begin
                cap_valid_d[i] = 1'b1;
                cap_data_d[i]  = sel_value[i];
            end
        end
    end

    always_comb begin
        state_d = StRun;
        if (flush) begin
            state_d = StRun;
        end else if (stall_req) begin
            state_d = StLoadWait;
        end else if (consumer_hold) begin
            state_d = StHeld;
        end
    end

    always_comb begin
        count_d = count_q;
        if (stall_req && (count_q != '1)) begin
            count_d = count_q + 1'b1;
        end
    end

    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            cap_valid_q <= '0;
            for (int i = 0; i < int'(NSRC); i++) begin
                cap_data_q[i] <= '0;
            end
            state_q <= StRun;
            count_q <= '0;
        end else begin
            cap_valid_q <= cap_valid_d;
            for (int i = 0; i < int'(NSRC); i++) begin
                cap_data_q[i] <= cap_data_d[i];
            end
            state_q <= state_d;
            count_q <= count_d;
        end
    end

    assign fwd_state   = state_q;
    assign stall_count = count_q;

endmodule
